// File: rtl/fan_mode_controller_if.sv
// rtl/fan_mode_controller_if.sv - button pulses in, fan status out
// Debouncer pulses in, speed/LED/PWM/timer status out.
interface fan_mode_controller_if;
    logic       i_btn_power;
    logic       i_btn_speed;
    logic       i_btn_timer;
    logic [1:0] o_speed;
    logic [3:0] o_led;
    logic       o_pwm;
    logic       o_timer_active;
    logic [7:0] o_timer_remain;

    modport master (
        output i_btn_power, i_btn_speed, i_btn_timer,
        input  o_speed, o_led, o_pwm, o_timer_active, o_timer_remain
    );

    modport slave (
        input  i_btn_power, i_btn_speed, i_btn_timer,
        output o_speed, o_led, o_pwm, o_timer_active, o_timer_remain
    );
endinterface

// File: rtl/fan_mode_controller.sv
// rtl/fan_mode_controller.sv - fan speed FSM with PWM output and auto-off timer
// Power beats timer expiry beats speed; any entry into OFF clears the timer.
module fan_mode_controller #(
    parameter int unsigned     PWM_PERIOD = 100,
    parameter int unsigned     DUTY_LOW   = 30,
    parameter int unsigned     DUTY_MID   = 60,
    parameter int unsigned     DUTY_HIGH  = 90,
    parameter longint unsigned TICK_DIV   = 200
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    fan_mode_controller_if.slave  bus
);

    localparam int unsigned CNT_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int unsigned PSC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_DIV - 64'd1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_LOW  = 2'd1,
        ST_MID  = 2'd2,
        ST_HIGH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       preset_q, preset_d;
    logic [7:0]       remain_q, remain_d;
    logic             active_q, active_d;
    logic [PSC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             tick;
    logic             expiry;
    logic [1:0]       preset_inc;
    logic [31:0]      duty_sel;

    function automatic logic [7:0] preset_units(input logic [1:0] idx);
        case (idx)
            2'd1:    preset_units = 8'd1;
            2'd2:    preset_units = 8'd3;
            2'd3:    preset_units = 8'd5;
            default: preset_units = 8'd0;
        endcase
    endfunction

    assign tick       = active_q && (presc_q == PSC_LAST);
    assign expiry     = tick && (remain_q == 8'd1);
    assign preset_inc = preset_q + 2'd1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_OFF;
            preset_q <= 2'd0;
            remain_q <= 8'd0;
            active_q <= 1'b0;
            presc_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            preset_q <= preset_d;
            remain_q <= remain_d;
            active_q <= active_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        preset_d = preset_q;
        remain_d = remain_q;
        active_d = active_q;
        presc_d  = '0;
        cnt_d    = '0;

        if (active_q) begin
            presc_d = tick ? '0 : presc_q + PSC_W'(1);
            if (tick) begin
                remain_d = remain_q - 8'd1;
            end
        end

        case (state_q)
            ST_OFF: begin
                if (bus.i_btn_power) begin
                    state_d = ST_LOW;
                end
            end
            default: begin
                if (bus.i_btn_power || expiry) begin
                    state_d  = ST_OFF;
                    preset_d = 2'd0;
                    remain_d = 8'd0;
                    active_d = 1'b0;
                    presc_d  = '0;
                end else begin
                    if (bus.i_btn_speed) begin
                        state_d = (state_q == ST_HIGH) ? ST_LOW : state_t'(state_q + 2'd1);
                    end
                    // A load restarts the full count even if a tick lands on this edge.
                    if (bus.i_btn_timer) begin
                        preset_d = preset_inc;
                        remain_d = preset_units(preset_inc);
                        active_d = (preset_inc != 2'd0);
                        presc_d  = '0;
                    end
                end
            end
        endcase

        // Held at 0 in OFF so the first period after power-on starts at count 0.
        if ((state_q != ST_OFF) && (state_d != ST_OFF)) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        duty_sel = 32'd0;
        case (state_q)
            ST_LOW:  duty_sel = DUTY_LOW;
            ST_MID:  duty_sel = DUTY_MID;
            ST_HIGH: duty_sel = DUTY_HIGH;
            default: duty_sel = 32'd0;
        endcase
    end

    assign bus.o_speed        = state_q;
    assign bus.o_led          = 4'b0001 << state_q;
    assign bus.o_pwm          = (state_q != ST_OFF) && (32'(cnt_q) < duty_sel);
    assign bus.o_timer_active = active_q;
    assign bus.o_timer_remain = remain_q;

    a_remain_bound: assert property (@(posedge i_clk) disable iff (i_reset)
        bus.o_timer_remain <= 8'd5);
    a_off_timer_idle: assert property (@(posedge i_clk) disable iff (i_reset)
        (state_q == ST_OFF) |-> (!active_q && remain_q == 8'd0));

endmodule
